bypass_ctrl: RTL and testbench

BYPASS_CTRL -- requirements
Module: bypass_ctrl

---
 rtl/bypass_ctrl_pkg.sv | 37 +++
 rtl/bypass_ctrl_if.sv | 35 +++
 rtl/bypass_ctrl_fwd_sel.sv | 44 ++++
 rtl/bypass_ctrl.sv | 114 +++++++++++
 tb/tb_bypass_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bypass_ctrl_pkg.sv
// Shared definitions for the bypass/hazard controller: register-file geometry,
// instruction kinds, forwarding select codes and the pipeline tracker record.
package bypass_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int NREGS  = 32;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'b00,
    KIND_LOAD = 2'b01,
    KIND_LONG = 2'b10,
    KIND_RSVD = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,
    SEL_EXE = 2'b01,
    SEL_WB  = 2'b10,
    SEL_LNG = 2'b11
  } sel_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
    kind_e            kind;
  } slot_t;

  localparam int SLOT_W = $bits(slot_t);

  // Long ops deliver their result through the long unit, never through WB.
  function automatic logic result_at_wb(slot_t s);
    return s.valid & s.we & (s.kind != KIND_LONG);
  endfunction

endpackage

// File: rtl/bypass_ctrl_if.sv
// Decode-side request and bypass-control response bundle of bypass_ctrl.
interface bypass_ctrl_if;
  import bypass_ctrl_pkg::*;

  logic             flush_i;
  logic             id_valid_i;
  logic [REG_W-1:0] id_rs1_i;
  logic [REG_W-1:0] id_rs2_i;
  logic             id_use_rs1_i;
  logic             id_use_rs2_i;
  logic [REG_W-1:0] id_rd_i;
  logic             id_we_i;
  logic [1:0]       id_kind_i;
  logic             lng_done_i;
  logic [REG_W-1:0] lng_rd_i;
  logic             stall_o;
  logic [1:0]       fwd_rs1_sel_o;
  logic [1:0]       fwd_rs2_sel_o;
  logic [REG_W-1:0] wb_dst_o;
  logic             wb_we_o;
  logic [NREGS-1:0] busy_o;

  modport master (
    output flush_i, id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rd_i, id_we_i, id_kind_i, lng_done_i, lng_rd_i,
    input  stall_o, fwd_rs1_sel_o, fwd_rs2_sel_o, wb_dst_o, wb_we_o, busy_o
  );

  modport slave (
    input  flush_i, id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rd_i, id_we_i, id_kind_i, lng_done_i, lng_rd_i,
    output stall_o, fwd_rs1_sel_o, fwd_rs2_sel_o, wb_dst_o, wb_we_o, busy_o
  );

endinterface

// File: rtl/bypass_ctrl_fwd_sel.sv
// Per-source hazard evaluation: forwarding select by producer priority plus
// the load-use and scoreboard stall contributions of one source operand.
module fwd_sel
  import bypass_ctrl_pkg::*;
(
  input  logic             used,
  input  logic [REG_W-1:0] src,
  input  slot_t            exe,
  input  slot_t            wb,
  input  logic [NREGS-1:0] busy,
  input  logic             lng_done,
  input  logic [REG_W-1:0] lng_rd,
  output sel_e             sel,
  output logic             load_use,
  output logic             busy_stall
);

  logic live;
  logic exe_hit;
  logic exe_alu;
  logic wb_hit;
  logic lng_hit;

  // x0 never creates a dependency, whatever the producers claim.
  assign live       = used & (src != '0);
  assign exe_hit    = live & exe.valid & exe.we & (exe.rd == src);
  assign exe_alu    = (exe.kind == KIND_ALU) | (exe.kind == KIND_RSVD);
  assign wb_hit     = live & result_at_wb(wb) & (wb.rd == src);
  assign lng_hit    = live & lng_done & (lng_rd == src);
  assign load_use   = exe_hit & (exe.kind == KIND_LOAD);
  assign busy_stall = live & busy[src] & ~lng_hit;

  always_comb begin
    sel = SEL_RF;
    if (exe_hit & exe_alu) begin
      sel = SEL_EXE;
    end else if (wb_hit) begin
      sel = SEL_WB;
    end else if (lng_hit) begin
      sel = SEL_LNG;
    end
  end

endmodule

// File: rtl/bypass_ctrl.sv
// Bypass/hazard controller: tracks EXE and WB producers, keeps the long-op
// scoreboard, and produces decode stall plus operand forwarding selects.
module bypass_ctrl
  import bypass_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  bypass_ctrl_if.slave bus
);

  slot_t            exe_reg, exe_next;
  slot_t            wb_reg, wb_next;
  logic [NREGS-1:0] busy_reg, busy_next;
  logic [NREGS-1:0] busy_set, busy_clr;
  logic [REG_W-1:0] wb_dst_reg;
  logic             wb_we_reg, wb_we_next;

  kind_e            id_kind;
  logic             issue;
  logic             long_issue;
  logic             waw;
  logic             stall;

  sel_e             sel_arr  [2];
  logic             used_arr [2];
  logic [REG_W-1:0] src_arr  [2];
  logic [1:0]       load_use;
  logic [1:0]       busy_stall;

  assign id_kind     = kind_e'(bus.id_kind_i);
  assign used_arr[0] = bus.id_use_rs1_i;
  assign used_arr[1] = bus.id_use_rs2_i;
  assign src_arr[0]  = bus.id_rs1_i;
  assign src_arr[1]  = bus.id_rs2_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      fwd_sel u_fwd_sel (
        .used       (used_arr[gi]),
        .src        (src_arr[gi]),
        .exe        (exe_reg),
        .wb         (wb_reg),
        .busy       (busy_reg),
        .lng_done   (bus.lng_done_i),
        .lng_rd     (bus.lng_rd_i),
        .sel        (sel_arr[gi]),
        .load_use   (load_use[gi]),
        .busy_stall (busy_stall[gi])
      );
    end
  endgenerate

  // A completing long op frees its destination for a new writer this cycle.
  assign waw   = bus.id_we_i & busy_reg[bus.id_rd_i]
               & ~(bus.lng_done_i & (bus.lng_rd_i == bus.id_rd_i));
  assign stall = bus.id_valid_i & ((|load_use) | (|busy_stall) | waw);

  // Flush kills the instruction sitting in decode as well as EXE/WB.
  assign issue      = bus.id_valid_i & ~stall & ~bus.flush_i;
  assign long_issue = issue & bus.id_we_i & (id_kind == KIND_LONG);

  assign busy_set[0] = 1'b0;
  assign busy_clr[0] = 1'b0;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_busy
      assign busy_set[gi] = long_issue & (bus.id_rd_i == REG_W'(gi));
      assign busy_clr[gi] = bus.lng_done_i & (bus.lng_rd_i == REG_W'(gi));
    end
  endgenerate

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  assign busy_next = (busy_reg & ~busy_clr) | busy_set;

  always_comb begin
    exe_next       = exe_reg;
    exe_next.valid = 1'b0;
    if (issue) begin
      exe_next.valid = 1'b1;
      exe_next.rd    = bus.id_rd_i;
      exe_next.we    = bus.id_we_i;
      exe_next.kind  = id_kind;
    end
    wb_next = exe_reg;
    if (bus.flush_i) begin
      wb_next.valid = 1'b0;
    end
    wb_we_next = result_at_wb(wb_next) & (wb_next.rd != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exe_reg    <= '0;
      wb_reg     <= '0;
      busy_reg   <= '0;
      wb_dst_reg <= '0;
      wb_we_reg  <= 1'b0;
    end else begin
      exe_reg    <= exe_next;
      wb_reg     <= wb_next;
      busy_reg   <= busy_next;
      wb_dst_reg <= wb_next.rd;
      wb_we_reg  <= wb_we_next;
    end
  end

  assign bus.stall_o       = stall;
  assign bus.fwd_rs1_sel_o = bus.id_valid_i ? sel_arr[0] : SEL_RF;
  assign bus.fwd_rs2_sel_o = bus.id_valid_i ? sel_arr[1] : SEL_RF;
  assign bus.wb_dst_o      = wb_dst_reg;
  assign bus.wb_we_o       = wb_we_reg;
  assign bus.busy_o        = busy_reg;

endmodule

// File: tb/tb_bypass_ctrl.sv
// Self-checking bench for bypass_ctrl: directed hazard scenarios followed by
// randomized traffic compared against a register-level behavioural model.
module tb_bypass_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  bypass_ctrl_if bus ();

  bypass_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Model: what each pipeline stage holds and which registers await a long op.
  typedef struct {
    bit valid;
    int rd;
    bit we;
    int kind;
  } op_t;

  op_t       m_exe, m_wb;
  bit [31:0] m_busy;

  task automatic idle();
    bus.flush_i      = 1'b0;
    bus.id_valid_i   = 1'b0;
    bus.id_rs1_i     = '0;
    bus.id_rs2_i     = '0;
    bus.id_use_rs1_i = 1'b0;
    bus.id_use_rs2_i = 1'b0;
    bus.id_rd_i      = '0;
    bus.id_we_i      = 1'b0;
    bus.id_kind_i    = 2'b00;
    bus.lng_done_i   = 1'b0;
    bus.lng_rd_i     = '0;
  endtask

  task automatic drive_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic we,
                          input logic [1:0] kind);
    bus.id_valid_i   = 1'b1;
    bus.id_rs1_i     = rs1;
    bus.id_use_rs1_i = u1;
    bus.id_rs2_i     = rs2;
    bus.id_use_rs2_i = u2;
    bus.id_rd_i      = rd;
    bus.id_we_i      = we;
    bus.id_kind_i    = kind;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_exe  = '{0, 0, 0, 0};
    m_wb   = '{0, 0, 0, 0};
    m_busy = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    n_cmp++; if (bus.busy_o !== 32'h0) begin n_err++; $display("FAIL reset_busy: got %h want 0", bus.busy_o); end
    n_cmp++; if (bus.wb_we_o !== 1'b0) begin n_err++; $display("FAIL reset_wb_we: got %b want 0", bus.wb_we_o); end
    n_cmp++; if (bus.wb_dst_o !== 5'd0) begin n_err++; $display("FAIL reset_wb_dst: got %0d want 0", bus.wb_dst_o); end
    rst = 1'b0;
    drive_id(5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 2'b00);
    #1;
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.stall_o); end
    n_cmp++; if (bus.fwd_rs1_sel_o !== 2'b00) begin n_err++; $display("FAIL reset_sel1: got %b want 00", bus.fwd_rs1_sel_o); end
    n_cmp++; if (bus.fwd_rs2_sel_o !== 2'b00) begin n_err++; $display("FAIL reset_sel2: got %b want 00", bus.fwd_rs2_sel_o); end
    $display("test_reset done");
  endtask

  task automatic test_alu_fwd();
    do_reset();
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'b00);
    #1;
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL alu_issue_stall: got %b want 0", bus.stall_o); end
    tick();
    drive_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 2'b00);
    #1;
    n_cmp++; if (bus.fwd_rs1_sel_o !== 2'b01) begin n_err++; $display("FAIL alu_exe_sel: got %b want 01", bus.fwd_rs1_sel_o); end
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL alu_exe_stall: got %b want 0", bus.stall_o); end
    tick();
    drive_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 2'b00);
    #1;
    n_cmp++; if (bus.fwd_rs1_sel_o !== 2'b10) begin n_err++; $display("FAIL alu_wb_sel: got %b want 10", bus.fwd_rs1_sel_o); end
    n_cmp++; if (bus.wb_dst_o !== 5'd5) begin n_err++; $display("FAIL alu_wb_dst: got %0d want 5", bus.wb_dst_o); end
    n_cmp++; if (bus.wb_we_o !== 1'b1) begin n_err++; $display("FAIL alu_wb_we: got %b want 1", bus.wb_we_o); end
    idle();
    $display("test_alu_fwd done");
  endtask

  task automatic test_load_use();
    do_reset();
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 2'b01);
    tick();
    drive_id(5'd0, 1'b0, 5'd6, 1'b1, 5'd12, 1'b1, 2'b00);
    #1;
    n_cmp++; if (bus.stall_o !== 1'b1) begin n_err++; $display("FAIL load_use_stall: got %b want 1", bus.stall_o); end
    tick();
    #1;
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL load_use_release: got %b want 0", bus.stall_o); end
    n_cmp++; if (bus.fwd_rs2_sel_o !== 2'b10) begin n_err++; $display("FAIL load_wb_sel: got %b want 10", bus.fwd_rs2_sel_o); end
    tick();
    idle();
    $display("test_load_use done");
  endtask

  task automatic test_long();
    do_reset();
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'b10);
    tick();
    idle();
    #1;
    n_cmp++; if (bus.busy_o !== 32'h80) begin n_err++; $display("FAIL long_busy_set: got %h want 00000080", bus.busy_o); end
    drive_id(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.stall_o !== 1'b1) begin n_err++; $display("FAIL long_wait_stall[%0d]: got %b want 1", i, bus.stall_o); end
      tick();
    end
    bus.lng_done_i = 1'b1;
    bus.lng_rd_i   = 5'd7;
    #1;
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL long_done_stall: got %b want 0", bus.stall_o); end
    n_cmp++; if (bus.fwd_rs1_sel_o !== 2'b11) begin n_err++; $display("FAIL long_done_sel: got %b want 11", bus.fwd_rs1_sel_o); end
    tick();
    idle();
    #1;
    n_cmp++; if (bus.busy_o[7] !== 1'b0) begin n_err++; $display("FAIL long_busy_clear: got %b want 0", bus.busy_o[7]); end
    $display("test_long done");
  endtask

  task automatic test_waw_x0();
    do_reset();
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'b10);
    tick();
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'b00);
    #1;
    n_cmp++; if (bus.stall_o !== 1'b1) begin n_err++; $display("FAIL waw_stall: got %b want 1", bus.stall_o); end
    bus.lng_done_i = 1'b1;
    bus.lng_rd_i   = 5'd7;
    #1;
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL waw_done_stall: got %b want 0", bus.stall_o); end
    do_reset();
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'b00);
    tick();
    drive_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 2'b10);
    #1;
    n_cmp++; if (bus.fwd_rs1_sel_o !== 2'b00) begin n_err++; $display("FAIL x0_sel1: got %b want 00", bus.fwd_rs1_sel_o); end
    n_cmp++; if (bus.fwd_rs2_sel_o !== 2'b00) begin n_err++; $display("FAIL x0_sel2: got %b want 00", bus.fwd_rs2_sel_o); end
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL x0_stall: got %b want 0", bus.stall_o); end
    tick();
    idle();
    #1;
    n_cmp++; if (bus.busy_o !== 32'h0) begin n_err++; $display("FAIL x0_busy: got %h want 0", bus.busy_o); end
    n_cmp++; if (bus.wb_we_o !== 1'b0) begin n_err++; $display("FAIL x0_wb_we: got %b want 0", bus.wb_we_o); end
    $display("test_waw_x0 done");
  endtask

  task automatic test_flush();
    do_reset();
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'b00);
    tick();
    // A second x9 writer sits in decode during the flush and must not issue.
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'b00);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    drive_id(5'd9, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 2'b00);
    #1;
    n_cmp++; if (bus.fwd_rs1_sel_o !== 2'b00) begin n_err++; $display("FAIL flush_sel: got %b want 00", bus.fwd_rs1_sel_o); end
    n_cmp++; if (bus.wb_we_o !== 1'b0) begin n_err++; $display("FAIL flush_wb_we: got %b want 0", bus.wb_we_o); end
    tick();
    idle();
    $display("test_flush done");
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'b10);
    tick();
    drive_id(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00);
    #1;
    n_cmp++; if (bus.busy_o !== 32'h80) begin n_err++; $display("FAIL arst_pre_busy: got %h want 00000080", bus.busy_o); end
    n_cmp++; if (bus.stall_o !== 1'b1) begin n_err++; $display("FAIL arst_pre_stall: got %b want 1", bus.stall_o); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.busy_o !== 32'h0) begin n_err++; $display("FAIL arst_busy: got %h want 0", bus.busy_o); end
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL arst_stall: got %b want 0", bus.stall_o); end
    tick();
    rst = 1'b0;
    idle();
    $display("test_async_reset done");
  endtask

  function automatic bit exe_load_hits(int src);
    return m_exe.valid && m_exe.we && m_exe.kind == 1 && m_exe.rd == src;
  endfunction

  function automatic int ref_sel(bit used, int src);
    if (!bus.id_valid_i || !used || src == 0) return 0;
    if (m_exe.valid && m_exe.we && (m_exe.kind == 0 || m_exe.kind == 3) && m_exe.rd == src) return 1;
    if (m_wb.valid && m_wb.we && m_wb.kind != 2 && m_wb.rd == src) return 2;
    if (bus.lng_done_i && int'(bus.lng_rd_i) == src) return 3;
    return 0;
  endfunction

  function automatic bit src_blocks(bit used, int src);
    if (!used || src == 0) return 0;
    if (exe_load_hits(src)) return 1;
    return m_busy[src] && !(bus.lng_done_i && int'(bus.lng_rd_i) == src);
  endfunction

  function automatic bit ref_stall();
    int rd;
    rd = int'(bus.id_rd_i);
    if (!bus.id_valid_i) return 0;
    if (src_blocks(bus.id_use_rs1_i, int'(bus.id_rs1_i))) return 1;
    if (src_blocks(bus.id_use_rs2_i, int'(bus.id_rs2_i))) return 1;
    return bus.id_we_i && m_busy[rd] && !(bus.lng_done_i && int'(bus.lng_rd_i) == rd);
  endfunction

  task automatic test_random();
    logic [1:0] want_sel1, want_sel2;
    logic       want_stall, want_we;
    bit         issued;
    int         pick, start;
    do_reset();
    for (int t = 0; t < 400; t++) begin
      bus.id_valid_i   = ($urandom_range(0, 3) != 0);
      bus.id_rs1_i     = 5'($urandom_range(0, 7));
      bus.id_rs2_i     = 5'($urandom_range(0, 7));
      bus.id_use_rs1_i = 1'($urandom_range(0, 1));
      bus.id_use_rs2_i = 1'($urandom_range(0, 1));
      bus.id_rd_i      = 5'($urandom_range(0, 7));
      bus.id_we_i      = ($urandom_range(0, 4) != 0);
      bus.id_kind_i    = 2'($urandom_range(0, 3));
      bus.flush_i      = ($urandom_range(0, 11) == 0);
      bus.lng_done_i   = 1'b0;
      bus.lng_rd_i     = '0;
      if (m_busy != 0 && $urandom_range(0, 2) == 0) begin
        start = $urandom_range(0, 31);
        pick  = -1;
        for (int k = 0; k < 32; k++) begin
          if (pick < 0 && m_busy[(start + k) % 32]) pick = (start + k) % 32;
        end
        bus.lng_done_i = 1'b1;
        bus.lng_rd_i   = 5'(pick);
      end else if ($urandom_range(0, 9) == 0) begin
        bus.lng_done_i = 1'b1;
        bus.lng_rd_i   = 5'($urandom_range(0, 7));
      end
      want_stall = ref_stall();
      want_sel1  = 2'(ref_sel(bus.id_use_rs1_i, int'(bus.id_rs1_i)));
      want_sel2  = 2'(ref_sel(bus.id_use_rs2_i, int'(bus.id_rs2_i)));
      #1;
      n_cmp++; if (bus.stall_o !== want_stall) begin n_err++; $display("FAIL rnd_stall t=%0d: got %b want %b", t, bus.stall_o, want_stall); end
      n_cmp++; if (bus.fwd_rs1_sel_o !== want_sel1) begin n_err++; $display("FAIL rnd_sel1 t=%0d: got %b want %b", t, bus.fwd_rs1_sel_o, want_sel1); end
      n_cmp++; if (bus.fwd_rs2_sel_o !== want_sel2) begin n_err++; $display("FAIL rnd_sel2 t=%0d: got %b want %b", t, bus.fwd_rs2_sel_o, want_sel2); end
      issued = bus.id_valid_i && !want_stall && !bus.flush_i;
      m_wb = m_exe;
      if (bus.flush_i) m_wb.valid = 0;
      m_exe = '{issued, int'(bus.id_rd_i), bus.id_we_i, int'(bus.id_kind_i)};
      if (bus.lng_done_i) m_busy[bus.lng_rd_i] = 1'b0;
      if (issued && bus.id_kind_i == 2'b10 && bus.id_we_i) m_busy[bus.id_rd_i] = 1'b1;
      m_busy[0] = 1'b0;
      $display("rnd t=%0d v=%b rs1=%0d/%b rs2=%0d/%b rd=%0d we=%b k=%0d fl=%b ld=%b/%0d -> st=%b s1=%b s2=%b",
               t, bus.id_valid_i, bus.id_rs1_i, bus.id_use_rs1_i, bus.id_rs2_i, bus.id_use_rs2_i,
               bus.id_rd_i, bus.id_we_i, bus.id_kind_i, bus.flush_i, bus.lng_done_i, bus.lng_rd_i,
               bus.stall_o, bus.fwd_rs1_sel_o, bus.fwd_rs2_sel_o);
      tick();
      want_we = m_wb.valid && m_wb.we && m_wb.kind != 2 && m_wb.rd != 0;
      n_cmp++; if (bus.wb_we_o !== want_we) begin n_err++; $display("FAIL rnd_wb_we t=%0d: got %b want %b", t, bus.wb_we_o, want_we); end
      if (want_we) begin
        n_cmp++; if (int'(bus.wb_dst_o) != m_wb.rd) begin n_err++; $display("FAIL rnd_wb_dst t=%0d: got %0d want %0d", t, bus.wb_dst_o, m_wb.rd); end
      end
      n_cmp++; if (bus.busy_o !== m_busy) begin n_err++; $display("FAIL rnd_busy t=%0d: got %h want %h", t, bus.busy_o, m_busy); end
    end
    idle();
    $display("test_random done");
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_long();
    test_waw_x0();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
